fifo_rd_stream: RTL
===================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side drain stage placed directly downstream of the async FIFO, in the rd_clk domain.
//  Converts the FIFO's pop interface (rd_en / fifo_empty / rd_data, data one cycle after rd_en)
//  into a first-word-fall-through valid/ready stream.
//  Prefetches into a 2-entry output buffer, so full throughput is sustained under backpressure.
//  Also provides synchronous flush and a delivered-word counter.
// PARAMETERS
//  WIDTH      32  data width; equals the FIFO WIDTH
//  CNT_WIDTH  32  width of word_cnt
// PORTS
//  rd_clk        in   1          sole clock (FIFO read clock)
//  rd_rst        in   1          reset, asynchronous, active-high
//  fifo_empty    in   1          FIFO empty flag
//  fifo_rd_en    out  1          FIFO pop request
//  fifo_rd_data  in   WIDTH      FIFO read data, valid the cycle after an accepted fifo_rd_en
//  flush         in   1          synchronous discard of buffered and in-flight data
//  m_valid       out  1          output word valid
//  m_ready       in   1          downstream accepts
//  m_data        out  WIDTH      output word, head of buffer
//  level         out  2          entries held in buffer (0..2)
//  word_cnt      out  CNT_WIDTH  count of completed m_valid&m_ready handshakes
// BEHAVIOUR
//  Reset:
//   - rd_rst high -> buffer cleared, in-flight flag cleared.
//   - fifo_rd_en=0, m_valid=0, m_data=0, level=0, word_cnt=0, immediately and asynchronously.
//   - Reset mid-transfer drops all held/in-flight data.
//  Buffer:
//   - 2-entry circular buffer with 1-bit rd/wr pointers.
//   - States EMPTY(level 0) / ONE(1) / TWO(2), moved by push (returned data) and pop (handshake).
//   - Push and pop in the same cycle keep the level unchanged.
//  Pop:
//   - pop = m_valid & m_ready.
//   - m_valid = (level!=0) & ~flush; m_data = entry at rd pointer.
//   - m_data is held stable while m_valid & ~m_ready.
//  Issue rule (combinational):
//   - fifo_rd_en = ~fifo_empty & ~flush & (level + inflight - pop < 2).
//   - inflight is a register, set the cycle after fifo_rd_en; it never exceeds 1 outstanding per cycle.
//   - fifo_rd_en is never high while fifo_empty=1.
//  Push:
//   - When inflight=1, fifo_rd_data is written at the wr pointer at the end of that cycle.
//   - Overflow is impossible by the issue rule.
//  Latency:
//   - fifo_rd_en in cycle N -> data captured at the edge ending N+1 -> m_valid in cycle N+2.
//   - First word: fifo_empty falls in cycle N -> m_valid in cycle N+2.
//   - Steady state: one word per cycle while m_ready=1 and the FIFO is non-empty.
//  Flush:
//   - In the flush cycle, m_valid=0 and fifo_rd_en=0, and no pop or count occurs.
//   - Next cycle: level=0 and the pointers are reset.
//   - A word in flight during the flush cycle is discarded when it returns.
//  Counter: word_cnt increments on each pop and wraps modulo 2^CNT_WIDTH; only rd_rst clears it.
//  level is registered, equal to buffer occupancy.
// TESTING
//  1. FIFO holds 0x1..0x8, m_ready=1 -> m_data 0x1..0x8 on 8 consecutive cycles,
//     first m_valid 2 cycles after fifo_empty falls; 8 fifo_rd_en pulses; word_cnt=8.
//  2. FIFO holds 4 words, m_ready=0 -> exactly 2 fifo_rd_en pulses, level=2, m_data=word0 stable;
//     then m_ready=1 -> words 0..3 in order, no gaps.
//  3. Flush asserted the cycle after fifo_rd_en with level=1
//     -> flush cycle m_valid=0; next cycle level=0; the returning word is not delivered;
//     the next FIFO word appears after flush deasserts.
//  4. fifo_empty toggles 1/0 each cycle during streaming -> fifo_rd_en never high while empty;
//     no word lost or duplicated (scoreboard).
//  5. rd_rst pulsed mid-stream with level=2 -> all outputs 0 during reset;
//     after release, m_valid=0 until a new fifo_rd_en completes.
//  6. CNT_WIDTH=4, deliver 17 words -> word_cnt=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side drain stage for an async FIFO (rd_clk domain).
//                Turns the FIFO pop interface (rd_en / empty / data one
//                cycle later) into a first-word-fall-through valid/ready
//                stream through a 2-entry prefetch buffer, with synchronous
//                flush and a delivered-word counter.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [1:0]           level,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    // Occupancy states; the encoding doubles as the level output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0]           c_SLOTS   = 3'd2;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_mem [2];
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic                   r_inflight;
    logic [CNT_WIDTH-1:0]   r_word_cnt;

    logic                   w_pop;
    logic                   w_push;
    logic [2:0]             w_occ;
    logic                   w_rd_en;

    // Handshake side: a word is offered whenever the buffer holds one,
    // except in a flush cycle, which must neither deliver nor count.
    assign m_valid = (r_state != EMPTY) && !flush;
    assign m_data  = r_mem[r_rd_ptr];
    assign w_pop   = m_valid && m_ready;

    // A returning word is dropped if it lands in the flush cycle.
    assign w_push  = r_inflight && !flush;

    // Committed slots after this cycle's pop: held words plus the word in
    // flight. A new pop request is issued only while a slot stays free, so
    // the buffer can never overflow. Gated by reset so the request is low
    // the instant reset rises, independent of the FIFO flag.
    assign w_occ   = {1'b0, r_state} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = !rd_rst && !fifo_empty && !flush && (w_occ < c_SLOTS);

    assign fifo_rd_en = w_rd_en;
    assign level      = r_state;
    assign word_cnt   = r_word_cnt;

    // Occupancy state register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy: push adds one, pop removes one, both cancel out;
    // flush empties the buffer unconditionally.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_next = ONE;
                end
            end
            ONE: begin
                if (w_push && !w_pop) begin
                    w_state_next = TWO;
                end else if (!w_push && w_pop) begin
                    w_state_next = EMPTY;
                end
            end
            TWO: begin
                if (w_pop && !w_push) begin
                    w_state_next = ONE;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
        if (flush) begin
            w_state_next = EMPTY;
        end
    end

    // Buffer storage: returned FIFO data is written at the write pointer.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_rd_data;
        end
    end

    // Circular pointers; flush realigns both to slot 0.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // In-flight flag: the FIFO returns data the cycle after a pop request.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    // Delivered-word counter, wraps naturally; only reset clears it.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + c_CNT_ONE;
        end
    end

endmodule
`default_nettype wire
